// File: rtl/dror_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dror_pkg
//  Description : Shared defaults, FSM state encoding and a constant clog2
//                helper for the DROR dispatch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package dror_pkg;

    localparam int DEF_N           = 16;
    localparam int DEF_CORE_NUMBER = 16;
    localparam int DEF_IDX_W       = 32;
    localparam int DEF_FIFO_DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dror_dispatch_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : dror_dispatch_controller_if
//  Description : Point-cache and validator-core bus of the DROR dispatch
//                controller. master = controller side, slave = cache/cores.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dror_dispatch_controller_if #(
    parameter int N           = 16,
    parameter int CORE_NUMBER = 16
);
    logic                   cache_valid;
    logic [N-1:0]           cache_x;
    logic [N-1:0]           cache_y;
    logic [N-1:0]           cache_z;
    logic                   cache_consume;
    logic [CORE_NUMBER-1:0] core_done;
    logic [CORE_NUMBER-1:0] core_outlier;
    logic [CORE_NUMBER-1:0] core_load;
    logic [N-1:0]           core_point_x;
    logic [N-1:0]           core_point_y;
    logic [N-1:0]           core_point_z;

    modport master (
        input  cache_valid, cache_x, cache_y, cache_z, core_done, core_outlier,
        output cache_consume, core_load, core_point_x, core_point_y, core_point_z
    );

    modport slave (
        output cache_valid, cache_x, cache_y, cache_z, core_done, core_outlier,
        input  cache_consume, core_load, core_point_x, core_point_y, core_point_z
    );
endinterface
`default_nettype wire

// File: rtl/dror_outlier_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dror_outlier_fifo
//  Description : Synchronous show-ahead FIFO of outlier point indices with
//                occupancy count. Push while full and pop while empty are
//                dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module dror_outlier_fifo
    import dror_pkg::*;
#(
    parameter int IDX_W      = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [IDX_W-1:0]             push_data,
    input  logic                         pop,
    output logic [IDX_W-1:0]             head,
    output logic                         empty,
    output logic                         full,
    output logic [clog2(FIFO_DEPTH):0]   count
);
    localparam int AW    = clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    logic [IDX_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Forced to zero when empty so the head reads 0 straight out of reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo the depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/dror_dispatch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dror_dispatch_controller
//  Description : Hands cached LiDAR points to a pool of validator cores
//                (lowest free core first) and retires finished cores
//                round-robin, queueing outlier indices for the host.
//  Revision    : 1.0 - initial release
// ============================================================================
module dror_dispatch_controller
    import dror_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int CORE_NUMBER = DEF_CORE_NUMBER,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        pause,
    input  logic [IDX_W-1:0]            point_cloud_size,
    dror_dispatch_controller_if.master  bus,
    input  logic                        fifo_rd,
    output logic [IDX_W-1:0]            fifo_dout,
    output logic                        fifo_empty,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [IDX_W-1:0]            retired_count,
    output logic                        busy,
    output logic                        done
);
    localparam int SEL_W = (CORE_NUMBER > 1) ? clog2(CORE_NUMBER) : 1;

    state_t                 state;
    logic [CORE_NUMBER-1:0] core_busy;
    logic [IDX_W-1:0]       core_idx [CORE_NUMBER];
    logic [IDX_W-1:0]       next_idx;
    logic [IDX_W-1:0]       size_q;
    logic [SEL_W-1:0]       rr_ptr;
    // Core verdicts are registered once; load_q/load_d mask the two cycles in
    // which a freshly loaded core may still show its previous verdict.
    logic [CORE_NUMBER-1:0] done_q;
    logic [CORE_NUMBER-1:0] outl_q;
    logic [CORE_NUMBER-1:0] load_q;
    logic [CORE_NUMBER-1:0] load_d;
    logic                   consume_q;
    logic [N-1:0]           point_x;
    logic [N-1:0]           point_y;
    logic [N-1:0]           point_z;

    logic                   disp_en;
    logic [SEL_W-1:0]       disp_sel;
    logic [CORE_NUMBER-1:0] ret_cand;
    logic                   ret_en;
    logic [SEL_W-1:0]       ret_sel;
    logic [SEL_W-1:0]       ret_j;
    logic                   push;
    logic [IDX_W-1:0]       push_idx;
    logic                   fifo_full;

    assign bus.core_load     = load_q;
    assign bus.cache_consume = consume_q;
    assign bus.core_point_x  = point_x;
    assign bus.core_point_y  = point_y;
    assign bus.core_point_z  = point_z;

    // Dispatch pick: lowest-numbered free core. The cycle with cache_consume
    // high is skipped because the cache still shows the point just taken.
    always_comb begin
        disp_en  = 1'b0;
        disp_sel = '0;
        for (int k = CORE_NUMBER - 1; k >= 0; k--) begin
            if (!core_busy[k]) begin
                disp_en  = 1'b1;
                disp_sel = SEL_W'(k);
            end
        end
        disp_en = disp_en && (state == RUN) && !pause && bus.cache_valid &&
                  !consume_q && (next_idx != size_q);
    end

    // Retire pick: round-robin from rr_ptr. Outlier candidates wait while the
    // FIFO is full; inliers proceed.
    always_comb begin
        ret_cand = core_busy & done_q & ~load_q & ~load_d &
                   ~(outl_q & {CORE_NUMBER{fifo_full}});
        ret_en   = 1'b0;
        ret_sel  = '0;
        ret_j    = '0;
        for (int i = 0; i < CORE_NUMBER; i++) begin
            ret_j = SEL_W'((int'(rr_ptr) + i) % CORE_NUMBER);
            if (!ret_en && ret_cand[ret_j]) begin
                ret_en  = 1'b1;
                ret_sel = ret_j;
            end
        end
        ret_en   = ret_en && !pause && ((state == RUN) || (state == DRAIN));
        push     = ret_en && outl_q[ret_sel];
        push_idx = core_idx[ret_sel];
    end

    // Run sequencing, per-core bookkeeping and registered core-bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            next_idx      <= '0;
            size_q        <= '0;
            retired_count <= '0;
            rr_ptr        <= '0;
            core_busy     <= '0;
            done_q        <= '0;
            outl_q        <= '0;
            load_q        <= '0;
            load_d        <= '0;
            consume_q     <= 1'b0;
            point_x       <= '0;
            point_y       <= '0;
            point_z       <= '0;
            for (int k = 0; k < CORE_NUMBER; k++) begin
                core_idx[k] <= '0;
            end
        end else begin
            done_q    <= bus.core_done;
            outl_q    <= bus.core_outlier;
            load_d    <= load_q;
            load_q    <= '0;
            consume_q <= 1'b0;

            if (disp_en) begin
                load_q[disp_sel]    <= 1'b1;
                consume_q           <= 1'b1;
                point_x             <= bus.cache_x;
                point_y             <= bus.cache_y;
                point_z             <= bus.cache_z;
                core_busy[disp_sel] <= 1'b1;
                core_idx[disp_sel]  <= next_idx;
                next_idx            <= next_idx + IDX_W'(1);
            end

            if (ret_en) begin
                core_busy[ret_sel] <= 1'b0;
                retired_count      <= retired_count + IDX_W'(1);
                rr_ptr             <= SEL_W'((int'(ret_sel) + 1) % CORE_NUMBER);
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        size_q        <= point_cloud_size;
                        next_idx      <= '0;
                        retired_count <= '0;
                        if (point_cloud_size == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (next_idx == size_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (core_busy == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dror_outlier_fifo #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_idx),
        .pop       (fifo_rd),
        .head      (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule
`default_nettype wire
